// File: rtl/ibex_xif_icache_mem_responder.sv
// Memory-side responder for the icache fetch bus: fixed-latency, in-order
// rvalid/rdata/err answers with bounded outstanding requests and an error window.
module ibex_xif_icache_mem_responder #(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] SEED        = 32'hDEADBEEF,
  parameter logic [31:0] ERR_BASE    = 32'hFFFF_0000,
  parameter logic [31:0] ERR_LIMIT   = 32'hFFFF_FFFF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_i,
  input  logic [31:0]                        addr_i,
  input  logic                               stall_i,
  output logic                               gnt_o,
  output logic                               rvalid_o,
  output logic [31:0]                        rdata_o,
  output logic                               err_o,
  output logic [$clog2(OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int unsigned CNT_W      = $clog2(OUTSTANDING + 1);
  localparam int unsigned PTR_W      = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned AGE_W      = $clog2(LATENCY + 1);
  localparam int unsigned LAUNCH_AGE = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam bit          ERR_EN     = (ERR_BASE <= ERR_LIMIT);
  localparam logic [31:0] ERR_SPAN   = ERR_LIMIT - ERR_BASE;

  logic [29:0]      addr_mem_q [OUTSTANDING];
  logic [29:0]      addr_mem_d [OUTSTANDING];
  logic [AGE_W-1:0] age_q      [OUTSTANDING];
  logic [AGE_W-1:0] age_d      [OUTSTANDING];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             full, fifo_empty, accept, head_ready, bypass;
  logic             launch, push, pop, in_err;
  logic [AGE_W-1:0] head_age;
  logic [29:0]      launch_addr;
  logic [31:0]      launch_byte_addr;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_W'(LATENCY)) ? a : a + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count_q == CNT_W'(OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign gnt_o      = req_i & ~stall_i & ~rst & ~full;
  assign accept     = gnt_o;

  // Ages are evaluated as they stand at this edge: stored age plus one.
  assign head_age   = age_inc(age_q[rd_ptr_q]);
  assign head_ready = (LATENCY == 1) || (head_age >= AGE_W'(LAUNCH_AGE));

  // With LATENCY=1 a request accepted into an empty queue answers at its own accept edge.
  assign bypass = fifo_empty & accept & (LATENCY == 1);
  assign launch = ~rst & ((~fifo_empty & head_ready) | bypass);
  assign push   = accept & ~bypass;
  assign pop    = launch & ~fifo_empty;

  assign launch_addr      = fifo_empty ? addr_i[31:2] : addr_mem_q[rd_ptr_q];
  assign launch_byte_addr = {launch_addr, 2'b00};
  assign in_err           = ERR_EN && ((launch_byte_addr - ERR_BASE) <= ERR_SPAN);

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    rvalid_d = launch;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (launch) begin
      err_d   = in_err;
      rdata_d = in_err ? 32'h0 : (launch_byte_addr ^ SEED);
    end
  end

  always_comb begin
    addr_mem_d = addr_mem_q;
    for (int i = 0; i < int'(OUTSTANDING); i++) begin
      age_d[i] = age_inc(age_q[i]);
      if (push && (wr_ptr_q == PTR_W'(i))) begin
        addr_mem_d[i] = addr_i[31:2];
        age_d[i]      = '0;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // NOTE: queue storage is not reset; a slot is only read after a push has written it.
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    age_q      <= age_d;
  end

  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;
  assign outstanding_o = count_q;

endmodule

// File: tb/tb_ibex_xif_icache_mem_responder.sv
// Bench for ibex_xif_icache_mem_responder: three configurations share one stimulus,
// each checked every cycle against a timestamp-based response model.
module tb_ibex_xif_icache_mem_responder;

  localparam int NDUT = 3;
  localparam logic [31:0] SEED = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] addr = 32'h0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic        gnt_w    [NDUT];
  logic        rvalid_w [NDUT];
  logic        err_w    [NDUT];
  logic [31:0] rdata_w  [NDUT];
  logic [3:0]  out_w    [NDUT];
  logic [2:0]  out0, out1;
  logic [1:0]  out2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ibex_xif_icache_mem_responder #(.OUTSTANDING(4), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .stall_i(stall),
    .gnt_o(gnt_w[0]), .rvalid_o(rvalid_w[0]), .rdata_o(rdata_w[0]), .err_o(err_w[0]),
    .outstanding_o(out0));

  ibex_xif_icache_mem_responder #(.OUTSTANDING(4), .LATENCY(8)) dut1 (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .stall_i(stall),
    .gnt_o(gnt_w[1]), .rvalid_o(rvalid_w[1]), .rdata_o(rdata_w[1]), .err_o(err_w[1]),
    .outstanding_o(out1));

  ibex_xif_icache_mem_responder #(.OUTSTANDING(2), .LATENCY(1)) dut2 (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .stall_i(stall),
    .gnt_o(gnt_w[2]), .rvalid_o(rvalid_w[2]), .rdata_o(rdata_w[2]), .err_o(err_w[2]),
    .outstanding_o(out2));

  assign out_w[0] = {1'b0, out0};
  assign out_w[1] = {1'b0, out1};
  assign out_w[2] = {2'b00, out2};

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int outs_of(input int k);
    return (k == 2) ? 2 : 4;
  endfunction

  function automatic logic in_err_window(input logic [31:0] a);
    logic [63:0] wa;
    wa = {32'h0, a};
    return (wa >= 64'h0000_0000_FFFF_0000) && (wa <= 64'h0000_0000_FFFF_FFFF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model: each accepted request is stamped with the cycle its rvalid must appear.
  typedef struct {
    int          id;
    logic [31:0] a;
    int          r;
  } ent_t;

  ent_t        mq[$];
  int          last_r   [NDUT];
  logic [31:0] exp_rdata[NDUT];
  logic        exp_err  [NDUT];
  bit          chk_en = 1'b0;

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      last_r[k]    = 0;
      exp_rdata[k] = 32'h0;
      exp_err[k]   = 1'b0;
    end
  end

  always @(negedge clk) begin
    int          cnt;
    bit          hit;
    logic [31:0] la;
    logic        eg;
    int          r;
    for (int k = 0; k < NDUT; k++) begin
      cnt = 0;
      hit = 1'b0;
      la  = 32'h0;
      foreach (mq[i]) begin
        if (mq[i].id == k) begin
          if (mq[i].r > cyc) cnt++;
          if (mq[i].r == cyc) begin
            hit = 1'b1;
            la  = mq[i].a;
          end
        end
      end
      if (hit) begin
        exp_err[k]   = in_err_window(la);
        exp_rdata[k] = exp_err[k] ? 32'h0 : (la ^ SEED);
      end
      eg = req & ~stall & ~rst & (cnt != outs_of(k));
      if (chk_en) begin
        check($sformatf("d%0d_gnt@%0d", k, cyc),    32'(gnt_w[k]),    32'(eg));
        check($sformatf("d%0d_rvalid@%0d", k, cyc), 32'(rvalid_w[k]), 32'(hit));
        check($sformatf("d%0d_rdata@%0d", k, cyc),  rdata_w[k],       exp_rdata[k]);
        check($sformatf("d%0d_err@%0d", k, cyc),    32'(err_w[k]),    32'(exp_err[k]));
        check($sformatf("d%0d_outst@%0d", k, cyc),  32'(out_w[k]),    32'(cnt));
      end
      if (!rst && eg) begin
        r = cyc + lat_of(k);
        if (r <= last_r[k]) r = last_r[k] + 1;
        last_r[k] = r;
        mq.push_back('{id: k, a: {addr[31:2], 2'b00}, r: r});
      end
    end
    if (rst) begin
      mq.delete();
      for (int k = 0; k < NDUT; k++) begin
        exp_rdata[k] = 32'h0;
        exp_err[k]   = 1'b0;
        last_r[k]    = 0;
      end
      chk_en = 1'b1;
    end
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].r <= cyc) mq.delete(i);
  end

  // Inputs change just after a posedge; control returns at the following negedge.
  task automatic tick(input logic r, input logic [31:0] a, input logic s, input logic rs);
    @(posedge clk);
    #1;
    req   = r;
    addr  = a;
    stall = s;
    rst   = rs;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and idle
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("idle_d%0d_gnt", k),    32'(gnt_w[k]),    32'd0);
      check($sformatf("idle_d%0d_rvalid", k), 32'(rvalid_w[k]), 32'd0);
      check($sformatf("idle_d%0d_rdata", k),  rdata_w[k],       32'h0);
      check($sformatf("idle_d%0d_err", k),    32'(err_w[k]),    32'd0);
      check($sformatf("idle_d%0d_outst", k),  32'(out_w[k]),    32'd0);
    end
    idle(4);

    // Single fetch, LATENCY=2
    tick(1'b1, 32'h0000_0100, 1'b0, 1'b0);
    check("single_gnt", 32'(gnt_w[0]), 32'd1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("single_outst_1", 32'(out_w[0]), 32'd1);
    check("single_rvalid_early", 32'(rvalid_w[0]), 32'd0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("single_rvalid", 32'(rvalid_w[0]), 32'd1);
    check("single_rdata", rdata_w[0], 32'hDEADBFEF);
    check("single_err", 32'(err_w[0]), 32'd0);
    check("single_outst_0", 32'(out_w[0]), 32'd0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("single_rvalid_drop", 32'(rvalid_w[0]), 32'd0);
    check("single_rdata_hold", rdata_w[0], 32'hDEADBFEF);
    idle(12);

    // Back-to-back until full (dut1: OUTSTANDING=4, LATENCY=8; dut2: LATENCY=1)
    for (int i = 0; i < 20; i++) begin
      tick(i <= 8, (i < 4) ? 32'(i * 4) : 32'h10, 1'b0, 1'b0);
      case (i)
        1: begin
          check("b2b_l1_rvalid_1", 32'(rvalid_w[2]), 32'd1);
          check("b2b_l1_rdata_1", rdata_w[2], 32'hDEADBEEF);
        end
        2: check("b2b_l1_rdata_2", rdata_w[2], 32'hDEADBEEB);
        3: check("full_gnt_3", 32'(gnt_w[1]), 32'd1);
        4: begin
          check("full_gnt_4", 32'(gnt_w[1]), 32'd0);
          check("full_outst_4", 32'(out_w[1]), 32'd4);
        end
        7: check("full_gnt_7", 32'(gnt_w[1]), 32'd0);
        8: begin
          check("full_gnt_8", 32'(gnt_w[1]), 32'd1);
          check("full_rvalid_8", 32'(rvalid_w[1]), 32'd1);
          check("full_rdata_8", rdata_w[1], 32'hDEADBEEF);
        end
        11: check("full_rdata_11", rdata_w[1], 32'hDEADBEE3);
        12: check("full_rvalid_12", 32'(rvalid_w[1]), 32'd0);
        16: begin
          check("full_rvalid_16", 32'(rvalid_w[1]), 32'd1);
          check("full_rdata_16", rdata_w[1], 32'hDEADBEFF);
        end
        default: ;
      endcase
    end
    idle(5);

    // Error window, including the lower boundary and the top word
    for (int i = 0; i < 20; i++) begin
      case (i)
        0:       tick(1'b1, 32'hFFFF_0004, 1'b0, 1'b0);
        4:       tick(1'b1, 32'hFFFE_FFFC, 1'b0, 1'b0);
        8:       tick(1'b1, 32'hFFFF_0000, 1'b0, 1'b0);
        12:      tick(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        default: tick(1'b0, 32'h1234_5670, 1'b0, 1'b0);
      endcase
      case (i)
        2: begin
          check("err_hit_rvalid", 32'(rvalid_w[0]), 32'd1);
          check("err_hit_err", 32'(err_w[0]), 32'd1);
          check("err_hit_rdata", rdata_w[0], 32'h0);
        end
        3: check("err_hold", 32'(err_w[0]), 32'd1);
        6: begin
          check("err_below_err", 32'(err_w[0]), 32'd0);
          check("err_below_rdata", rdata_w[0], 32'h2153_4113);
        end
        10: check("err_base_err", 32'(err_w[0]), 32'd1);
        14: check("err_top_err", 32'(err_w[0]), 32'd1);
        default: ;
      endcase
    end
    idle(5);

    // Stall with a response already in flight
    for (int i = 0; i < 20; i++) begin
      if (i == 2)                tick(1'b1, 32'h200, 1'b0, 1'b0);
      else if (i >= 3 && i <= 5) tick(1'b1, 32'h990, 1'b1, 1'b0);
      else if (i == 6)           tick(1'b1, 32'h204, 1'b0, 1'b0);
      else                       tick(1'b0, 32'h0, 1'b0, 1'b0);
      case (i)
        2: check("stall_gnt_2", 32'(gnt_w[0]), 32'd1);
        3: check("stall_gnt_3", 32'(gnt_w[0]), 32'd0);
        4: begin
          check("stall_rvalid_4", 32'(rvalid_w[0]), 32'd1);
          check("stall_rdata_4", rdata_w[0], 32'hDEADBCEF);
        end
        5: check("stall_gnt_5", 32'(gnt_w[0]), 32'd0);
        6: check("stall_gnt_6", 32'(gnt_w[0]), 32'd1);
        8: check("stall_rdata_8", rdata_w[0], 32'hDEADBCEB);
        default: ;
      endcase
    end
    idle(12);

    // Reset with three requests outstanding in dut1
    for (int i = 0; i < 25; i++) begin
      if (i >= 7 && i <= 9) tick(1'b1, 32'h300 + 32'((i - 7) * 4), 1'b0, 1'b0);
      else if (i == 10)     tick(1'b1, 32'h30C, 1'b0, 1'b1);
      else if (i == 12)     tick(1'b1, 32'h400, 1'b0, 1'b0);
      else                  tick(1'b0, 32'h0, 1'b0, 1'b0);
      case (i)
        10: begin
          check("rst_outst_before", 32'(out_w[1]), 32'd3);
          check("rst_gnt_in_reset", 32'(gnt_w[0]), 32'd0);
        end
        11: begin
          check("rst_outst_after", 32'(out_w[1]), 32'd0);
          check("rst_rvalid_after", 32'(rvalid_w[0]), 32'd0);
          check("rst_rdata_after", rdata_w[0], 32'h0);
        end
        12: check("rst_new_gnt", 32'(gnt_w[1]), 32'd1);
        15: check("rst_dropped_rvalid", 32'(rvalid_w[1]), 32'd0);
        20: begin
          check("rst_new_rvalid", 32'(rvalid_w[1]), 32'd1);
          check("rst_new_rdata", rdata_w[1], 32'hDEADBAEF);
        end
        default: ;
      endcase
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
